// File: rtl/uart_pkt_framer.sv
// uart_pkt_framer: turns one cmd/data request into the frame {HEADER, CMD, DATA, CMD+DATA} written to the TX FIFO
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   req_valid/req_ready         request handshake; req_cmd, req_data, req_inject_err are latched on accept
//   fifo_full/fifo_wr_en        TX FIFO write handshake; fifo_wr_data carries the current frame byte
//   busy                        frame in progress
//   frame_cnt, err_frame_cnt    completed frames (wrapping) and corrupted frames (saturating)
module uart_pkt_framer #(
    parameter logic [7:0] HEADER = 8'h55,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_cmd,
    input  logic [7:0]       req_data,
    input  logic             req_inject_err,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_wr_data,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [7:0]       err_frame_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, CMD, DATA, CSUM} state_t;

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, data_q, chk;
    logic             inj_q, accept, csum_wr;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [7:0]       err_cnt_q;

    always_comb begin
        chk          = (cmd_q + data_q) ^ {7'd0, inj_q};
        busy         = state_q != IDLE;
        req_ready    = state_q == IDLE || (state_q == CSUM && !fifo_full);
        fifo_wr_en   = busy && !fifo_full;
        accept       = req_valid && req_ready;
        csum_wr      = fifo_wr_en && state_q == CSUM;
        fifo_wr_data = state_q == HDR  ? HEADER :
                       state_q == CMD  ? cmd_q  :
                       state_q == DATA ? data_q :
                       state_q == CSUM ? chk    : 8'h00;
        state_d      = state_q;
        // A request accepted while leaving CSUM chains straight into the next header.
        if (accept)
            state_d = HDR;
        else if (fifo_wr_en)
            state_d = state_q == HDR  ? CMD  :
                      state_q == CMD  ? DATA :
                      state_q == DATA ? CSUM : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= 8'h00;
            data_q      <= 8'h00;
            inj_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q  <= req_cmd;
                data_q <= req_data;
                inj_q  <= req_inject_err;
            end
            if (csum_wr) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
                if (inj_q && err_cnt_q != 8'hFF)
                    err_cnt_q <= err_cnt_q + 8'h01;
            end
        end
    end

    assign frame_cnt     = frame_cnt_q;
    assign err_frame_cnt = err_cnt_q;
endmodule

// File: tb/tb_uart_pkt_framer.sv
// tb_uart_pkt_framer: randomized scoreboard bench for uart_pkt_framer
module tb_uart_pkt_framer;
    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, req_inject_err, fifo_full, fifo_wr_en, busy;
    logic [7:0]  req_cmd, req_data, fifo_wr_data, err_frame_cnt;
    logic [15:0] frame_cnt;

    int         checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
    int         m_frames = 0, m_errs = 0;
    bit         rand_full = 0;
    logic [7:0] exp_q[$];
    int         wr_cyc[$];

    uart_pkt_framer #(.HEADER(8'h55), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_data(req_data), .req_inject_err(req_inject_err),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .frame_cnt(frame_cnt), .err_frame_cnt(err_frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every FIFO write pops the next expected byte.
    always @(negedge clk) begin
        if (fifo_wr_en && fifo_full) begin
            $display("FAIL overflow: wr_en=1 while fifo_full=1 at cycle %0d", cyc);
            $fatal(1, "write into full FIFO");
        end
        if (fifo_wr_en) begin
            logic [7:0] e;
            checks++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %02h, expected no write", fifo_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wr_data !== e) begin
                    errors++;
                    $display("FAIL wr_data: got %02h expected %02h", fifo_wr_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_full) fifo_full = ($urandom_range(99) < 30);
    endtask

    // Reference model: a frame is header, cmd, data, and the 8-bit sum (LSB flipped when corrupted).
    task automatic model_push(input logic [7:0] c, input logic [7:0] d, input bit inj);
        logic [7:0] s;
        s = 8'((int'(c) + int'(d)) % 256);
        exp_q.push_back(8'h55);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(inj ? s ^ 8'h01 : s);
        m_frames++;
        if (inj && m_errs < 255) m_errs++;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] d, input bit inj);
        int n = 0;
        bit done = 0;
        req_valid = 1; req_cmd = c; req_data = d; req_inject_err = inj;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                acc_cyc = cyc;
                model_push(c, d, inj);
            end else if (++n > 1000) begin
                done = 1;
                checks++; errors++;
                $display("FAIL accept_timeout: got no req_ready, expected ready within 1000 cycles");
            end
            tick();
        end
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        repeat (n) begin
            req_cmd = 8'($urandom); req_data = 8'($urandom); req_inject_err = 1'($urandom);
            tick();
        end
    endtask

    task automatic drain();
        int n = 0;
        req_valid = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 2000, 1);
    endtask

    initial begin
        rst = 1; req_valid = 0; req_cmd = 0; req_data = 0; req_inject_err = 0; fifo_full = 0;
        tick();
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_err_cnt", err_frame_cnt, 0);
        tick();
        rst = 0;

        // Single frame: latency and ready profile.
        wr_cyc.delete();
        send(8'h01, 8'h3C, 0);
        req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ready_mid_frame", req_ready, 0);
            tick();
        end
        @(negedge clk);
        chk("ready_in_csum", req_ready, 1);
        drain();
        chk("single_writes", wr_cyc.size(), 4);
        if (wr_cyc.size() == 4) begin
            chk("hdr_latency", wr_cyc[0] - acc_cyc, 1);
            chk("csum_latency", wr_cyc[3] - acc_cyc, 4);
        end
        chk("single_frame_cnt", frame_cnt, 1);

        // Checksum wrap, clean then corrupted.
        send(8'hF0, 8'h20, 0);
        send(8'hF0, 8'h20, 1);
        drain();
        chk("wrap_err_cnt", err_frame_cnt, 1);
        chk("wrap_frame_cnt", frame_cnt, 3);

        // Back-to-back with valid held high.
        wr_cyc.delete();
        send(8'h11, 8'h22, 0);
        send(8'h33, 8'h44, 0);
        send(8'h55, 8'h66, 1);
        drain();
        chk("b2b_writes", wr_cyc.size(), 12);
        if (wr_cyc.size() == 12) chk("b2b_span", wr_cyc[11] - wr_cyc[0], 11);
        chk("b2b_frame_cnt", frame_cnt, 6);

        // Backpressure while in DATA.
        wr_cyc.delete();
        send(8'h9A, 8'hBC, 0);
        req_valid = 0;
        tick();
        tick();
        fifo_full = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_wr_en", fifo_wr_en, 0);
            chk("bp_wr_data", fifo_wr_data, 8'hBC);
            tick();
        end
        fifo_full = 0;
        drain();
        chk("bp_writes", wr_cyc.size(), 4);
        chk("bp_frame_cnt", frame_cnt, 7);

        // Reset right after the CMD write.
        send(8'hAA, 8'hBB, 0);
        req_valid = 0;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        exp_q.delete();
        m_frames = 0;
        m_errs = 0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_wr_en", fifo_wr_en, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_err_cnt", err_frame_cnt, 0);
        idle(5);
        send(8'h02, 8'h05, 0);
        drain();
        chk("post_rst_frame_cnt", frame_cnt, 1);

        // Randomized traffic with random backpressure and mid-frame input churn.
        rand_full = 1;
        repeat (80) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(1) == 0) idle($urandom_range(0, 4));
        end
        rand_full = 0;
        fifo_full = 0;
        drain();
        chk("rand_frame_cnt", frame_cnt, 16'(m_frames));
        chk("rand_err_cnt", err_frame_cnt, 8'(m_errs));

        // Error counter saturation.
        repeat (260) send(8'($urandom), 8'($urandom), 1);
        drain();
        chk("sat_err_cnt", err_frame_cnt, 8'hFF);
        chk("sat_frame_cnt", frame_cnt, 16'(m_frames));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_pkt_framer.md
Name: uart_pkt_framer

Overview:
Transmit-side packet framer for the UART command link. It accepts one command/data pair per handshake and serialises it into the 4-byte frame {0x55, CMD, DATA, CMD+DATA} as writes into the TX FIFO write port (wr_en/wr_data/full). The receive-side command parser decodes exactly this frame. The block sits between user/control logic and the TX FIFO of the UART top.

Parameters:
HEADER, 8'h55, frame sync byte emitted first in every frame
CNT_W, 16, width of the transmitted-frame counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  command request valid
req_ready  output  1  framer can accept a request this cycle
req_cmd  input  8  command byte
req_data  input  8  data byte
req_inject_err  input  1  corrupt checksum of this frame (sampled with request)
fifo_full  input  1  TX FIFO full flag
fifo_wr_en  output  1  TX FIFO write strobe
fifo_wr_data  output  8  byte to TX FIFO
busy  output  1  frame in progress (state != IDLE)
frame_cnt  output  CNT_W  frames fully written, wraps
err_frame_cnt  output  8  frames written with injected bad checksum, saturates at 255

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk. Forces state=IDLE and clears frame_cnt, err_frame_cnt and the latched cmd/data/inject registers to 0. In IDLE: req_ready=1, fifo_wr_en=0, fifo_wr_data=8'h00, busy=0.
- States: IDLE, HDR, CMD, DATA, CSUM.
- Acceptance: a request is accepted on a cycle with req_valid && req_ready. The block then latches req_cmd, req_data and req_inject_err and moves to HDR.
- req_ready = (state==IDLE) || (state==CSUM && !fifo_full). Ready is combinational, so back-to-back frames are possible.
- Byte states (HDR/CMD/DATA/CSUM):
  - fifo_wr_en = !fifo_full (combinational).
  - fifo_wr_data: HDR=HEADER, CMD=cmd_q, DATA=data_q, CSUM=chk.
  - chk = (cmd_q + data_q) mod 256, XOR 8'h01 when inject_q=1.
  - If fifo_wr_en=1, advance: HDR->CMD->DATA->CSUM.
  - Leaving CSUM: if a new request is accepted that same cycle, latch it and go to HDR; otherwise go to IDLE.
- Backpressure: while fifo_full=1 in any byte state, the block holds its state, keeps fifo_wr_en=0, and keeps fifo_wr_data stable. No byte is skipped or duplicated.
- fifo_wr_data outside byte states = 8'h00.
- Latency with FIFO never full:
  - Accept at cycle 0. HDR written at cycle 1, CMD at 2, DATA at 3, CSUM at 4.
  - Back-to-back throughput is 4 cycles per frame.
- Counters, updated on the CSUM write:
  - frame_cnt += 1, wraps at 2^CNT_W.
  - err_frame_cnt += 1 if inject_q=1, saturating at 8'hFF.
- Input handling: req_cmd/req_data/req_inject_err are ignored unless a request is accepted. Changing them mid-frame has no effect on the frame in progress.
- Reset mid-frame: the frame is abandoned and returns to IDLE next cycle. Bytes already written remain in the FIFO. The receive parser resynchronises by discarding bytes until it sees HEADER.
- Simulation check: fifo_wr_en && fifo_full must never be 1 in the same cycle; the bench halts if it is.

Test Plan:
- Single frame: cmd=0x01, data=0x3C, FIFO empty -> writes 0x55,0x01,0x3C,0x3D on cycles 1-4. req_ready is 0 on cycles 1-3. frame_cnt=1.
- Checksum wrap: cmd=0xF0, data=0x20 -> CSUM byte 0x10. Same frame with inject_err=1 -> 0x11, err_frame_cnt=1.
- Back-to-back: req_valid held high with 3 requests -> 12 consecutive writes, no idle gap, frame_cnt=3, frame byte order intact.
- Backpressure: fifo_full=1 for 5 cycles while in DATA -> no writes, fifo_wr_data stays at data byte. After release, DATA then CSUM are written once each.
- Reset mid-frame: assert rst after the CMD write -> next cycle IDLE, req_ready=1, counters 0, no further writes. Following frame 0x02/0x05 emits 0x55,0x02,0x05,0x07.
- Loopback: framer -> TX FIFO -> uart_tx -> uart_rx -> parser, cmd=0x01 data=0xA5 -> parser reg_file=0xA5, error_led=0. With inject_err=1 -> error_led=1.
